xrv_muldiv_ctrl: RTL and testbench
==================================

XRV_MULDIV_CTRL -- requirements
Module: xrv_muldiv_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- rstb  in  1  asynchronous active-low reset
- req_valid  in  1  M-extension request from the pipeline
- req_ready  out  1  controller can accept a request
- req_op  in  3  funct3: 0..3 multiply (MUL, MULH, MULHSU, MULHU), 4..7 divide (DIV, DIVU, REM, REMU)
- req_a / req_b  in  32 each  operands (rs1, rs2)
- req_rd  in  5  destination register tag
- flush  in  1  abort the current request
- unit_a / unit_b  out  32 each  registered operands to the multiply and divide units
- unit_optype  out  3  registered req_op
- mult_valid / div_valid  out  1 each  one-cycle start pulses
- mult_result_valid / div_result_valid  in  1 each  unit completion
- mult_result / div_result  in  32 each  unit results
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  result
- rsp_rd  out  5  tag
- busy  out  1  state != IDLE

Function
REQ-002 The state machine SHALL have the states IDLE, ISSUE, WAIT, RSP and DRAIN.
REQ-003 req_ready SHALL be 1 only in IDLE, and flush SHALL force req_ready to 0.
REQ-004 A request SHALL be accepted on req_valid&req_ready.
REQ-005 On acceptance the block SHALL register req_a, req_b, req_op and req_rd into unit_a, unit_b, unit_optype and the tag, and go to ISSUE.
REQ-006 In ISSUE the block SHALL assert exactly one start pulse for one cycle: mult_valid if optype[2]=0, otherwise div_valid. It SHALL then go to WAIT.
REQ-007 unit_a, unit_b and unit_optype SHALL stay stable from acceptance until the matching result_valid.
REQ-008 In WAIT, the result_valid of the selected unit SHALL capture that unit's result into rsp_data and move to RSP. result_valid from the non-selected unit SHALL be ignored.
REQ-009 In RSP, rsp_valid SHALL be 1. rsp_data and rsp_rd SHALL be held until rsp_ready, which returns the block to IDLE.
REQ-010 Latency SHALL be unit latency + 2 cycles from acceptance to rsp_valid. rsp_valid SHALL be registered.
REQ-011 Back-to-back operation: a new request SHALL be accepted no earlier than the cycle after the RSP handshake. Only one operation SHALL be outstanding at a time.
REQ-012 Flush rules, by state:
- flush in ISSUE: no start pulse; next state IDLE.
- flush in WAIT: next state DRAIN.
- flush in RSP: rsp_valid drops the next cycle; next state IDLE.
REQ-013 DRAIN SHALL wait for the selected unit's result_valid, discard it (no rsp_valid), then go to IDLE. If result_valid and flush arrive in the same WAIT cycle, the result SHALL be discarded and the next state SHALL be IDLE.
REQ-014 Division-by-zero and overflow results SHALL be passed through unmodified from the divide unit.

Reset
REQ-015 While rstb=0 the block SHALL be in IDLE with these outputs:
- req_ready=1
- mult_valid=0, div_valid=0
- rsp_valid=0, busy=0
- rsp_data=0, rsp_rd=0
- unit_a=0, unit_b=0, unit_optype=0
REQ-016 Reset asserted mid-operation SHALL abort immediately. A later stray result_valid in IDLE SHALL be ignored.

Configuration
REQ-017 With macro XRV_MULDIV_REUSE_EN defined:
- The block SHALL keep a one-entry cache of the last completed (a, b, op, result).
- A request whose a, b and op all equal the cache SHALL go IDLE -> RSP with the cached result: no start pulse, rsp_valid on the cycle after acceptance.
- The cache SHALL be invalidated by reset and by any flush.
REQ-018 Without XRV_MULDIV_REUSE_EN, no cache logic SHALL exist and every request SHALL issue to a unit.

Verification
REQ-019 MUL, a=7, b=-3, mult unit latency 3 -> one mult_valid pulse, then rsp_valid with rsp_data=0xFFFFFFEB, rsp_rd=req_rd, 5 cycles after acceptance.
REQ-020 DIVU, a=100, b=0 -> one div_valid pulse, no mult_valid; rsp_data=0xFFFFFFFF; req_ready=0 until the RSP handshake.
REQ-021 Response back-pressure: rsp_ready held 0 for 10 cycles in RSP -> rsp_valid, rsp_data and rsp_rd stable for all 10 cycles; the new request is accepted the cycle after rsp_ready=1.
REQ-022 Flush during WAIT of a DIV -> DRAIN until div_result_valid; no rsp_valid; busy=0 the cycle after; the next request then completes normally.
REQ-023 rstb pulsed low in WAIT, then a stray div_result_valid arrives -> IDLE, rsp_valid stays 0, outputs at reset values.
REQ-024 Cache hit (XRV_MULDIV_REUSE_EN): REM a=17, b=5 twice -> the second request gives no div_valid and rsp_data=2 one cycle after acceptance. A flush between the two requests forces a re-issue.

Source files
------------

// File: rtl/xrv_muldiv_ctrl.sv
// Sequencing controller between the pipeline and the M-extension multiply/divide units.
// Optional one-entry result reuse cache enabled by defining XRV_MULDIV_REUSE_EN.
module xrv_muldiv_ctrl (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic [2:0]  unit_optype,
    output logic        mult_valid,
    output logic        div_valid,
    input  logic        mult_result_valid,
    input  logic        div_result_valid,
    input  logic [31:0] mult_result,
    input  logic [31:0] div_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        busy
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 3;
    localparam int unsigned RDW  = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RSP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic capture;
    logic hit;
    logic sel_div;
    logic sel_done;

    assign sel_div  = unit_optype[OPW-1];
    assign sel_done = sel_div ? div_result_valid : mult_result_valid;
    assign busy     = (state != S_IDLE);

`ifdef XRV_MULDIV_REUSE_EN
    logic            cache_valid;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic [OPW-1:0]  cache_op;
    logic [XLEN-1:0] cache_result;

    assign hit = cache_valid && (req_a == cache_a) && (req_b == cache_b) && (req_op == cache_op);

    // Cache holds the last completed operation; any flush drops it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_op     <= '0;
            cache_result <= '0;
        end else if (flush) begin
            cache_valid  <= 1'b0;
        end else if (capture) begin
            cache_valid  <= 1'b1;
            cache_a      <= unit_a;
            cache_b      <= unit_b;
            cache_op     <= unit_optype;
            cache_result <= sel_div ? div_result : mult_result;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Next-state and handshake/start-pulse decode.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mult_valid = 1'b0;
        div_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = hit ? S_RSP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    mult_valid = !sel_div;
                    div_valid  = sel_div;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving together with flush is dropped outright.
                if (flush) begin
                    state_nxt = sel_done ? S_IDLE : S_DRAIN;
                end else if (sel_done) begin
                    capture   = 1'b1;
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (flush || rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (sel_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, tag and response registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            unit_a      <= '0;
            unit_b      <= '0;
            unit_optype <= '0;
            rsp_rd      <= '0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
        end else begin
            rsp_valid <= (state_nxt == S_RSP);
            if (accept) begin
                unit_a      <= XLEN'(req_a);
                unit_b      <= XLEN'(req_b);
                unit_optype <= OPW'(req_op);
                rsp_rd      <= RDW'(req_rd);
            end
`ifdef XRV_MULDIV_REUSE_EN
            if (accept && hit) begin
                rsp_data <= cache_result;
            end
`endif
            if (capture) begin
                rsp_data <= sel_div ? div_result : mult_result;
            end
        end
    end
endmodule

// File: tb/tb_xrv_muldiv_ctrl.sv
// Directed self-checking bench for xrv_muldiv_ctrl with behavioural multiply/divide unit models.
module tb_xrv_muldiv_ctrl;
    logic        clk;
    logic        rstb;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [2:0]  unit_optype;
    logic        mult_valid;
    logic        div_valid;
    logic        mult_result_valid;
    logic        div_result_valid;
    logic [31:0] mult_result;
    logic [31:0] div_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int   mult_lat = 3;
    int   div_lat  = 3;
    int   m_cnt    = 0;
    int   d_cnt    = 0;
    logic mult_rv_m = 1'b0;
    logic div_rv_m  = 1'b0;
    logic stray_mult;
    logic stray_div;

    assign mult_result_valid = mult_rv_m | stray_mult;
    assign div_result_valid  = div_rv_m | stray_div;

    xrv_muldiv_ctrl dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .unit_a(unit_a), .unit_b(unit_b), .unit_optype(unit_optype),
        .mult_valid(mult_valid), .div_valid(div_valid),
        .mult_result_valid(mult_result_valid), .div_result_valid(div_result_valid),
        .mult_result(mult_result), .div_result(div_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mul_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 3'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op == 3'd0 || op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Unit models: result_valid arrives <lat> cycles after the start pulse cycle.
    always @(posedge clk) begin
        mult_rv_m <= 1'b0;
        if (m_cnt == 1) begin
            mult_rv_m   <= 1'b1;
            mult_result <= mul_f(unit_optype, unit_a, unit_b);
        end
        if (m_cnt > 0) m_cnt <= m_cnt - 1;
        if (mult_valid) m_cnt <= mult_lat - 1;
    end

    always @(posedge clk) begin
        div_rv_m <= 1'b0;
        if (d_cnt == 1) begin
            div_rv_m   <= 1'b1;
            div_result <= div_f(unit_optype, unit_a, unit_b);
        end
        if (d_cnt > 0) d_cnt <= d_cnt - 1;
        if (div_valid) d_cnt <= div_lat - 1;
    end

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int k;
        req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
        k = 0;
        #1;
        while (!req_ready && k < 30) begin
            @(negedge clk); #1; k++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, k);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Counts cycles (acceptance = 0) until rsp_valid, plus start pulses and req_ready highs.
    task automatic wait_rsp(output int n, output int mp, output int dp, output int rr);
        n = 1; mp = 0; dp = 0; rr = 0;
        for (int i = 0; i < 60; i++) begin
            if (mult_valid) mp++;
            if (div_valid) dp++;
            if (req_ready) rr++;
            if (rsp_valid) break;
            @(negedge clk); n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if ({mult_valid, div_valid} !== 2'b00) begin errors++; $display("FAIL reset_start: got %b want 00", {mult_valid, div_valid}); end
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_rsp_busy: got %b want 00", {rsp_valid, busy}); end
        checks++; if (rsp_data !== 32'h0 || rsp_rd !== 5'h0) begin errors++; $display("FAIL reset_rsp: data %h rd %h want 0 0", rsp_data, rsp_rd); end
        checks++; if (unit_a !== 32'h0 || unit_b !== 32'h0 || unit_optype !== 3'h0) begin
            errors++; $display("FAIL reset_unit: a %h b %h op %h want 0", unit_a, unit_b, unit_optype); end
        @(negedge clk) rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int n, mp, dp, rr;
        send_req(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        wait_rsp(n, mp, dp, rr);
        checks++; if (n !== 5) begin errors++; $display("FAIL mul_latency: got %0d want 5", n); end
        checks++; if (mp !== 1 || dp !== 0) begin errors++; $display("FAIL mul_pulses: mult %0d div %0d want 1 0", mp, dp); end
        checks++; if (rsp_data !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: got %h want ffffffeb", rsp_data); end
        checks++; if (rsp_rd !== 5'd9) begin errors++; $display("FAIL mul_rd: got %0d want 9", rsp_rd); end
        handshake();
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mul_idle: busy %b ready %b want 0 1", busy, req_ready); end
        send_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_rsp(n, mp, dp, rr);
        checks++; if (rsp_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_data: got %h want fffffffe", rsp_data); end
        handshake();
    endtask

    task automatic test_div();
        int n, mp, dp, rr;
        send_req(3'd5, 32'd100, 32'd0, 5'd3);
        wait_rsp(n, mp, dp, rr);
        checks++; if (mp !== 0 || dp !== 1) begin errors++; $display("FAIL divu_pulses: mult %0d div %0d want 0 1", mp, dp); end
        checks++; if (rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_data: got %h want ffffffff", rsp_data); end
        checks++; if (rr !== 0) begin errors++; $display("FAIL divu_ready: req_ready high %0d cycles want 0", rr); end
        checks++; if (n !== 5) begin errors++; $display("FAIL divu_latency: got %0d want 5", n); end
        handshake();
        send_req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        wait_rsp(n, mp, dp, rr);
        checks++; if (rsp_data !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_data: got %h want 80000000", rsp_data); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int n, mp, dp, rr, bad;
        logic [31:0] d0;
        logic [4:0]  r0;
        send_req(3'd0, 32'd6, 32'd7, 5'd17);
        wait_rsp(n, mp, dp, rr);
        d0 = rsp_data; r0 = rsp_rd; bad = 0;
        checks++; if (d0 !== 32'd42 || r0 !== 5'd17) begin errors++; $display("FAIL bp_data: got %h rd %0d want 2a 17", d0, r0); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_rd !== r0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad); end
        req_op = 3'd1; req_a = 32'h0001_0000; req_b = 32'h0001_0000; req_rd = 5'd20;
        req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_early: req_ready %b in RSP want 0", req_ready); end
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: busy %b ready %b want 0 1", busy, req_ready); end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mult_valid !== 1'b1) begin errors++; $display("FAIL b2b_issue: mult_valid %b want 1", mult_valid); end
        wait_rsp(n, mp, dp, rr);
        checks++; if (n !== 5 || rsp_data !== 32'd1 || rsp_rd !== 5'd20) begin
            errors++; $display("FAIL b2b_rsp: lat %0d data %h rd %0d want 5 1 20", n, rsp_data, rsp_rd); end
        handshake();
    endtask

    task automatic test_flush_wait();
        int n, mp, dp, rr, rs;
        div_lat = 6;
        send_req(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd11);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        n = 3; rs = 0;
        while (busy && n < 30) begin
            if (rsp_valid) rs++;
            stray_mult = (n == 4);
            @(negedge clk); n++;
        end
        stray_mult = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL drain_idle_cycle: got %0d want 8", n); end
        checks++; if (rs !== 0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_rsp: rsp_valid seen %0d want 0", rs); end
        send_req(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd12);
        wait_rsp(n, mp, dp, rr);
        checks++; if (n !== 8 || dp !== 1 || rsp_data !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL post_drain: lat %0d div %0d data %h want 8 1 fffffffa", n, dp, rsp_data); end
        handshake();
        div_lat = 3;
    endtask

    task automatic test_flush_misc();
        int n, mp, dp, rr;
        send_req(3'd0, 32'd5, 32'd5, 5'd1);
        flush = 1'b1;
        #1;
        checks++; if (mult_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_pulse: mult_valid %b want 0", mult_valid); end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_issue_idle: busy %b want 0", busy); end
        send_req(3'd5, 32'd1000, 32'd10, 5'd5);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_with_result: busy %b rsp %b want 0 0", busy, rsp_valid); end
        send_req(3'd0, 32'd3, 32'd4, 5'd6);
        wait_rsp(n, mp, dp, rr);
        flush = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12) begin errors++; $display("FAIL flush_rsp_hold: rsp %b data %h want 1 c", rsp_valid, rsp_data); end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_rsp_drop: rsp %b busy %b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_reset_mid();
        int rs;
        send_req(3'd5, 32'd50, 32'd7, 5'd8);
        @(negedge clk) rstb = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || unit_a !== 32'h0 || rsp_rd !== 5'h0) begin
            errors++; $display("FAIL rst_mid_abort: busy %b a %h rd %h want 0 0 0", busy, unit_a, rsp_rd); end
        @(negedge clk) rstb = 1'b1;
        rs = 0;
        for (int i = 0; i < 6; i++) begin
            stray_div = (i == 3);
            @(negedge clk);
            if (rsp_valid || busy) rs++;
        end
        stray_div = 1'b0;
        checks++; if (rs !== 0) begin errors++; $display("FAIL rst_mid_stray: %0d active cycles want 0", rs); end
        checks++; if (rsp_data !== 32'h0 || unit_optype !== 3'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_outputs: data %h op %h ready %b want 0 0 1", rsp_data, unit_optype, req_ready); end
    endtask

    task automatic test_reuse();
        int n, mp, dp, rr, hit_lat, hit_dp;
`ifdef XRV_MULDIV_REUSE_EN
        hit_lat = 1; hit_dp = 0;
`else
        hit_lat = 5; hit_dp = 1;
`endif
        send_req(3'd6, 32'd17, 32'd5, 5'd13);
        wait_rsp(n, mp, dp, rr);
        checks++; if (n !== 5 || dp !== 1 || rsp_data !== 32'd2) begin
            errors++; $display("FAIL rem_first: lat %0d div %0d data %h want 5 1 2", n, dp, rsp_data); end
        handshake();
        send_req(3'd6, 32'd17, 32'd5, 5'd14);
        wait_rsp(n, mp, dp, rr);
        checks++; if (n !== hit_lat || dp !== hit_dp || rsp_data !== 32'd2 || rsp_rd !== 5'd14) begin
            errors++; $display("FAIL rem_second: lat %0d div %0d data %h rd %0d want %0d %0d 2 14", n, dp, rsp_data, rsp_rd, hit_lat, hit_dp); end
        handshake();
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        send_req(3'd6, 32'd17, 32'd5, 5'd15);
        wait_rsp(n, mp, dp, rr);
        checks++; if (n !== 5 || dp !== 1 || rsp_data !== 32'd2) begin
            errors++; $display("FAIL rem_after_flush: lat %0d div %0d data %h want 5 1 2", n, dp, rsp_data); end
        handshake();
    endtask

    initial begin
        req_valid = 1'b0; req_op = 3'd0; req_a = 32'h0; req_b = 32'h0; req_rd = 5'd0;
        flush = 1'b0; rsp_ready = 1'b0; stray_mult = 1'b0; stray_div = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush_wait();
        test_flush_misc();
        test_reset_mid();
        test_reuse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", checks);
        $fatal(1);
    end
endmodule
